// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide unit: the control state
// encoding and the MIPS SPECIAL funct codes that select the unit's operations.
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // SPECIAL funct field values. For 0x18-0x1B, funct[1] selects divide and
  // funct[0]==0 selects the signed variant.
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Bundle between the execute stage and the multiply/divide unit.
//   start, is_div, Sign, a, b : operation launch and operands
//   hi_we, lo_we, wdata       : MTHI/MTLO writes
//   busy, done, hi, lo        : status and architectural HI/LO
// Modports: master (pipeline side) drives requests; slave (unit) answers.
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_div;
  logic             Sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_div, Sign, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_div, Sign, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Every operation takes a fixed 33 edges after the accepting edge: 32 CALC
// iterations (one bit per cycle) plus one FIXUP cycle that applies signs and
// writes HI/LO.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : muldiv_if.slave (start/is_div/Sign/a/b/hi_we/lo_we/wdata in,
//           busy/done/hi/lo out)
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t             state_r;
  state_t             state_s;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r;
  logic               sign_r;
  logic               a_neg_r;
  logic               b_neg_r;
  logic               b_zero_r;
  logic [WIDTH-1:0]   orig_a_r;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]   opd_r;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits still to shift in / quotient}.
  logic [2*WIDTH-1:0] acc_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               start_ok_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     add_x_s;
  logic [WIDTH:0]     add_y_s;
  logic               sub_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] acc_calc_s;
  logic               neg_res_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  assign start_ok_s = (state_r == IDLE) && bus.start;
  assign a_neg_s    = bus.Sign & bus.a[WIDTH-1];
  assign b_neg_s    = bus.Sign & bus.b[WIDTH-1];
  assign a_mag_s    = cond_neg(bus.a, a_neg_s);
  assign b_mag_s    = cond_neg(bus.b, b_neg_s);

  // Shared adder operands: add for shift-add multiply, subtract for restoring divide.
  always_comb begin
    add_x_s = {(WIDTH+1){1'b0}};
    add_y_s = {(WIDTH+1){1'b0}};
    sub_s   = 1'b0;
    if (is_div_r) begin
      // Shift the next dividend bit into the partial remainder, then try the subtract.
      add_x_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      add_y_s = {1'b0, opd_r};
      sub_s   = 1'b1;
    end else begin
      add_x_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      add_y_s = acc_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}};
      sub_s   = 1'b0;
    end
  end

  assign sum_s = add_x_s + (add_y_s ^ {(WIDTH+1){sub_s}}) + {{WIDTH{1'b0}}, sub_s};

  // One iteration: divide keeps the difference when its top bit is clear
  // (non-negative) and shifts in the quotient bit; multiply shifts right.
  always_comb begin
    acc_calc_s = acc_r;
    if (is_div_r) begin
      acc_calc_s = {(sum_s[WIDTH] ? add_x_s[WIDTH-1:0] : sum_s[WIDTH-1:0]),
                    acc_r[WIDTH-2:0], ~sum_s[WIDTH]};
    end else begin
      acc_calc_s = {sum_s, acc_r[WIDTH-1:1]};
    end
  end

  assign neg_res_s = sign_r & (a_neg_r ^ b_neg_r);
  assign prod_s    = neg_res_s ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;

  // Final HI/LO values written in FIXUP; divide-by-zero bypasses the signed fixup.
  always_comb begin
    fix_hi_s = {WIDTH{1'b0}};
    fix_lo_s = {WIDTH{1'b0}};
    if (!is_div_r) begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end else if (b_zero_r) begin
      fix_hi_s = orig_a_r;
      fix_lo_s = {WIDTH{1'b1}};
    end else begin
      fix_hi_s = cond_neg(acc_r[2*WIDTH-1:WIDTH], sign_r & a_neg_r);
      fix_lo_s = cond_neg(acc_r[WIDTH-1:0], neg_res_s);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CW'(WIDTH - 1)) begin
          state_s = FIXUP;
        end else begin
          state_s = CALC;
        end
      end
      FIXUP:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath, HI/LO and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= {CW{1'b0}};
      is_div_r <= 1'b0;
      sign_r   <= 1'b0;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      b_zero_r <= 1'b0;
      orig_a_r <= {WIDTH{1'b0}};
      opd_r    <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // MTHI/MTLO land even on the edge that accepts start; FIXUP overwrites later.
          if (bus.hi_we) hi_r <= bus.wdata;
          if (bus.lo_we) lo_r <= bus.wdata;
          if (start_ok_s) begin
            is_div_r <= bus.is_div;
            sign_r   <= bus.Sign;
            a_neg_r  <= a_neg_s;
            b_neg_r  <= b_neg_s;
            b_zero_r <= (bus.b == {WIDTH{1'b0}});
            orig_a_r <= bus.a;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
            if (bus.is_div) begin
              opd_r <= b_mag_s;
              acc_r <= {{WIDTH{1'b0}}, a_mag_s};
            end else begin
              opd_r <= a_mag_s;
              acc_r <= {{WIDTH{1'b0}}, b_mag_s};
            end
          end
        end
        CALC: begin
          acc_r <= acc_calc_s;
          cnt_r <= cnt_r + CW'(1'b1);
        end
        FIXUP: begin
          hi_r   <= fix_hi_s;
          lo_r   <= fix_lo_s;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, got running, expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [5:0] fn,
                       input logic [31:0] opa, input logic [31:0] opb,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  n;
    bit  seen;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_div = fn[1];
    bus.Sign   = ~fn[0];
    bus.a      = opa;
    bus.b      = opb;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) seen = 1'b1;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'd33);
    check_eq({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    @(posedge clk); #1;
    check_eq({tag, "_done_1cyc"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int pulses;
    int lat;
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.is_div = 1'b0;
    bus.Sign   = 1'b0;
    bus.a      = 32'h0;
    bus.b      = 32'h0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_hi",   64'(bus.hi),   64'd0);
    check_eq("rst_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Main function
    do_op("mult_m3x5",   FN_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    do_op("multu_max",   FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    do_op("div_m7d2",    FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("div_7dm2",    FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    do_op("divu_100d7",  FN_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
    do_op("div_minm1",   FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    do_op("divu_7d0",    FN_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    do_op("div_m7d0",    FN_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // start and hi_we/lo_we while busy are ignored; HI/LO stay stale until done
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_div = FN_MULTU[1];
    bus.Sign   = ~FN_MULTU[0];
    bus.a      = 32'd6;
    bus.b      = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    pulses = 0;
    lat    = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        bus.start  = 1'b1;
        bus.is_div = 1'b1;
        bus.Sign   = 1'b0;
        bus.a      = 32'd99;
        bus.b      = 32'd3;
        bus.hi_we  = 1'b1;
        bus.lo_we  = 1'b1;
        bus.wdata  = 32'hDEAD;
      end
      @(posedge clk); #1;
      if (i == 5) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
      end
      if (i == 6) begin
        check_eq("busy_hi_stale", 64'(bus.hi), 64'hFFFFFFF9);
        check_eq("busy_lo_stale", 64'(bus.lo), 64'hFFFFFFFF);
      end
      if (bus.done) begin
        pulses++;
        if (lat == 0) lat = i;
      end
    end
    check_eq("busy_pulses", 64'(pulses), 64'd1);
    check_eq("busy_lat",    64'(lat),    64'd33);
    check_eq("busy_hi",     64'(bus.hi), 64'd0);
    check_eq("busy_lo",     64'(bus.lo), 64'd42);

    // MTHI / MTLO in IDLE
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check_eq("mthi_hi", 64'(bus.hi), 64'h1234);
    check_eq("mthi_lo", 64'(bus.lo), 64'd42);
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5678;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    check_eq("mtlo_lo", 64'(bus.lo), 64'h5678);
    check_eq("mtlo_hi", 64'(bus.hi), 64'h1234);

    // Reset in the middle of a MULT aborts it
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_div = FN_MULT[1];
    bus.Sign   = ~FN_MULT[0];
    bus.a      = 32'd3;
    bus.b      = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check_eq("abort_busy_pre", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_hi",   64'(bus.hi),   64'd0);
    check_eq("abort_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    check_eq("abort_no_done", 64'(pulses), 64'd0);
    check_eq("abort_lo_hold", 64'(bus.lo), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
